// File: rtl/beam_centroid.sv
// beam_centroid: buffers one frame of calibrated channels, sums the samples
// inside the located cluster window and divides the channel-weighted sum by
// the plain sum to produce a fixed-point beam centroid once per frame.
module beam_centroid #(
    parameter int NCH       = 320,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 8,
    parameter int QW        = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_caled_valid,
    input  logic [8:0]        data_caled_address,
    input  logic [DATA_W-1:0] data_caled,
    input  logic [8:0]        sig_ch_left,
    input  logic [8:0]        sig_ch_right,
    input  logic              has_cluster,
    input  logic              no_cluster,
    output logic [QW-1:0]     pos_data,
    output logic [40:0]       pos_sum,
    output logic [1:0]        pos_flags,
    output logic              pos_valid,
    output logic              busy,
    output logic [15:0]       overrun_cnt
);
    localparam int AW     = 9;
    localparam int SUM_W  = 41;
    localparam int WSUM_W = 50;
    localparam int DIV_W  = WSUM_W + FRAC_BITS;
    localparam int REM_W  = SUM_W + 1;
    localparam int CNT_W  = $clog2(QW + 1);
    localparam logic [AW:0] NCH_L  = (AW + 1)'(NCH);
    localparam logic [AW:0] LAST_L = NCH_L - 1'b1;

    typedef enum logic [2:0] {S_COLLECT, S_CHECK, S_ACCUM, S_DIVIDE, S_DONE} state_t;

    state_t state_reg, state_next;

    logic              busy_reg, frame_done_reg, cl_seen_reg, cl_no_reg;
    logic [AW-1:0]     left_reg, right_reg;
    logic [AW:0]       addr_reg;
    logic              rd_valid_reg;
    logic [AW-1:0]     rd_ch_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [SUM_W-1:0]  sum_reg;
    logic [WSUM_W-1:0] wsum_reg;
    logic [REM_W-1:0]  rem_reg;
    logic [QW-1:0]     dq_reg;
    logic [CNT_W-1:0]  div_cnt_reg;
    logic [1:0]        res_flags_reg;
    logic [QW-1:0]     pos_data_reg;
    logic [SUM_W-1:0]  pos_sum_reg;
    logic [1:0]        pos_flags_reg;
    logic              pos_valid_reg;
    logic [15:0]       overrun_reg;

    logic [DATA_W-1:0] mem [NCH];

    // Write/latch qualifiers shared by the FSM and the datapath
    logic wr_accept, last_wr, pulse_ok, frame_ready, check_err, issue;
    assign wr_accept   = data_caled_valid && !busy_reg && (state_reg == S_COLLECT)
                         && ({1'b0, data_caled_address} < NCH_L);
    assign last_wr     = wr_accept && ({1'b0, data_caled_address} == LAST_L);
    assign pulse_ok    = (has_cluster || no_cluster) && (state_reg != S_ACCUM)
                         && (state_reg != S_DIVIDE) && (state_reg != S_DONE);
    assign frame_ready = (frame_done_reg || last_wr) && (cl_seen_reg || pulse_ok);
    assign check_err   = (left_reg > right_reg) || ({1'b0, right_reg} >= NCH_L);
    assign issue       = (state_reg == S_ACCUM) && (addr_reg <= {1'b0, right_reg});

    // Negative calibrated samples contribute nothing to the centroid
    logic [DATA_W-1:0]    samp_pos;
    logic [AW+DATA_W-1:0] prod;
    assign samp_pos = rd_data_reg[DATA_W-1] ? '0 : rd_data_reg;
    assign prod     = (AW + DATA_W)'(rd_ch_reg) * (AW + DATA_W)'(samp_pos);

    // One restoring-division step; the first step seeds the partial remainder
    // with the dividend bits above the quotient field (always < sum because
    // the centroid cannot exceed NCH-1).
    logic [DIV_W-1:0] dividend;
    logic [REM_W-1:0] rem_cur, trial, rem_step;
    logic [QW-1:0]    dq_cur, dq_step;
    logic             ge;
    always_comb begin
        dividend = {wsum_reg, {FRAC_BITS{1'b0}}};
        rem_cur  = (div_cnt_reg == '0) ? REM_W'(dividend[DIV_W-1:QW]) : rem_reg;
        dq_cur   = (div_cnt_reg == '0) ? dividend[QW-1:0] : dq_reg;
        trial    = {rem_cur[REM_W-2:0], dq_cur[QW-1]};
        ge       = (trial >= {1'b0, sum_reg});
        rem_step = ge ? (trial - {1'b0, sum_reg}) : trial;
        dq_step  = {dq_cur[QW-2:0], ge};
    end

    // Frame buffer: collect writes, window reads with one cycle latency
    logic [AW-1:0] ram_addr;
    assign ram_addr = (state_reg == S_ACCUM) ? addr_reg[AW-1:0] : data_caled_address;
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[ram_addr] <= data_caled;
        rd_data_reg <= mem[ram_addr];
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_COLLECT;
        else      state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_COLLECT: if (frame_ready) state_next = S_CHECK;
            S_CHECK:   state_next = (cl_no_reg || check_err) ? S_DONE : S_ACCUM;
            S_ACCUM:   if (addr_reg > {1'b0, right_reg}) state_next = S_DIVIDE;
            S_DIVIDE:  if ((sum_reg == '0) || (div_cnt_reg == CNT_W'(QW - 1)))
                           state_next = S_DONE;
            S_DONE:    state_next = S_COLLECT;
            default:   state_next = S_COLLECT;
        endcase
    end

    // Datapath: cluster latch, overrun counter, accumulation, division, result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            cl_seen_reg    <= 1'b0;
            cl_no_reg      <= 1'b0;
            left_reg       <= '0;
            right_reg      <= '0;
            addr_reg       <= '0;
            rd_valid_reg   <= 1'b0;
            rd_ch_reg      <= '0;
            sum_reg        <= '0;
            wsum_reg       <= '0;
            rem_reg        <= '0;
            dq_reg         <= '0;
            div_cnt_reg    <= '0;
            res_flags_reg  <= '0;
            pos_data_reg   <= '0;
            pos_sum_reg    <= '0;
            pos_flags_reg  <= '0;
            pos_valid_reg  <= 1'b0;
            overrun_reg    <= '0;
        end else begin
            pos_valid_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
            if (last_wr)
                frame_done_reg <= 1'b1;
            if (pulse_ok) begin
                left_reg    <= sig_ch_left;
                right_reg   <= sig_ch_right;
                cl_no_reg   <= no_cluster;
                cl_seen_reg <= 1'b1;
            end
            if (data_caled_valid && busy_reg && (overrun_reg != 16'hFFFF))
                overrun_reg <= overrun_reg + 16'd1;
            case (state_reg)
                S_COLLECT: if (frame_ready) busy_reg <= 1'b1;
                S_CHECK: begin
                    addr_reg      <= {1'b0, left_reg};
                    sum_reg       <= '0;
                    wsum_reg      <= '0;
                    div_cnt_reg   <= '0;
                    res_flags_reg <= cl_no_reg ? 2'b01 : (check_err ? 2'b10 : 2'b00);
                end
                S_ACCUM: begin
                    if (issue) begin
                        addr_reg     <= addr_reg + 1'b1;
                        rd_valid_reg <= 1'b1;
                        rd_ch_reg    <= addr_reg[AW-1:0];
                    end
                    if (rd_valid_reg) begin
                        sum_reg  <= sum_reg + SUM_W'(samp_pos);
                        wsum_reg <= wsum_reg + WSUM_W'(prod);
                    end
                end
                S_DIVIDE: begin
                    if (sum_reg == '0) begin
                        res_flags_reg <= 2'b10;
                    end else begin
                        rem_reg     <= rem_step;
                        dq_reg      <= dq_step;
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    pos_valid_reg  <= 1'b1;
                    pos_flags_reg  <= res_flags_reg;
                    pos_data_reg   <= (res_flags_reg == 2'b00) ? dq_reg : '0;
                    pos_sum_reg    <= (res_flags_reg == 2'b00) ? sum_reg : '0;
                    busy_reg       <= 1'b0;
                    frame_done_reg <= 1'b0;
                    cl_seen_reg    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign pos_data    = pos_data_reg;
    assign pos_sum     = pos_sum_reg;
    assign pos_flags   = pos_flags_reg;
    assign pos_valid   = pos_valid_reg;
    assign busy        = busy_reg;
    assign overrun_cnt = overrun_reg;

endmodule

// File: tb/tb_beam_centroid.sv
// tb_beam_centroid: directed frames with a result scoreboard; expected
// centroids come from an integer model of the window sums.
module tb_beam_centroid;
    localparam int NCH = 320, DATA_W = 32, FRAC_BITS = 8, QW = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              data_caled_valid = 1'b0;
    logic [8:0]        data_caled_address = '0;
    logic [DATA_W-1:0] data_caled = '0;
    logic [8:0]        sig_ch_left = '0, sig_ch_right = '0;
    logic              has_cluster = 1'b0, no_cluster = 1'b0;
    logic [QW-1:0]     pos_data;
    logic [40:0]       pos_sum;
    logic [1:0]        pos_flags;
    logic              pos_valid, busy;
    logic [15:0]       overrun_cnt;

    int errors = 0;
    int checks = 0;
    int n_res  = 0;

    typedef struct {
        logic [QW-1:0] data;
        logic [40:0]   sum;
        logic [1:0]    flags;
    } res_t;
    res_t exp_q[$];
    int   model_mem[NCH];

    beam_centroid #(.NCH(NCH), .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .QW(QW)) dut (
        .clk(clk), .rst(rst),
        .data_caled_valid(data_caled_valid), .data_caled_address(data_caled_address),
        .data_caled(data_caled), .sig_ch_left(sig_ch_left), .sig_ch_right(sig_ch_right),
        .has_cluster(has_cluster), .no_cluster(no_cluster),
        .pos_data(pos_data), .pos_sum(pos_sum), .pos_flags(pos_flags),
        .pos_valid(pos_valid), .busy(busy), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) model_mem[i] = 0;
    endtask

    // Reference result for a window over the current model frame
    task automatic push_expected(input int l, input int r, input int kind);
        res_t   e;
        longint s, sum, wsum;
        sum = 0;
        wsum = 0;
        e.data = '0;
        e.sum = '0;
        if (kind != 0) begin
            e.flags = 2'b01;
        end else if (l > r || r >= NCH) begin
            e.flags = 2'b10;
        end else begin
            for (int ch = l; ch <= r; ch++) begin
                s = (model_mem[ch] < 0) ? 0 : longint'(model_mem[ch]);
                sum += s;
                wsum += longint'(ch) * s;
            end
            if (sum == 0) begin
                e.flags = 2'b10;
            end else begin
                e.flags = 2'b00;
                e.sum = 41'(sum);
                e.data = QW'((wsum * (longint'(1) << FRAC_BITS)) / sum);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_pulse(input int l, input int r, input int kind);
        sig_ch_left  = 9'(l);
        sig_ch_right = 9'(r);
        has_cluster  = (kind == 0 || kind == 2);
        no_cluster   = (kind == 1 || kind == 2);
    endtask

    task automatic clear_pulse();
        has_cluster = 1'b0;
        no_cluster  = 1'b0;
    endtask

    // Full frame 0..NCH-1 from the model; optional cluster pulse at index pulse_at
    task automatic send_frame(input int pulse_at, input int l, input int r);
        for (int i = 0; i < NCH; i++) begin
            data_caled_valid   = 1'b1;
            data_caled_address = 9'(i);
            data_caled         = DATA_W'(model_mem[i]);
            if (i == pulse_at) drive_pulse(l, r, 0);
            cyc();
            clear_pulse();
        end
        data_caled_valid = 1'b0;
    endtask

    // Wait for pos_valid, then pop and compare; ovr_n junk samples are sent while busy
    task automatic await_result(input string tag, input int exp_lat, input int max_lat, input int ovr_n);
        int   lat;
        bit   got;
        res_t e;
        lat = 0;
        got = 0;
        for (int k = 0; k < 400; k++) begin
            cyc();
            clear_pulse();
            lat++;
            if (k < ovr_n) begin
                data_caled_valid   = 1'b1;
                data_caled_address = 9'((k * 37) % NCH);
                data_caled         = 32'h0BAD_0000 + DATA_W'(k);
            end else begin
                data_caled_valid = 1'b0;
            end
            if (pos_valid) begin
                got = 1;
                break;
            end
        end
        data_caled_valid = 1'b0;
        check({tag, "_valid_seen"}, 64'(got), 64'd1);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_res++;
            $display("result %0d %s: data=%0d sum=%0d flags=%0d latency=%0d",
                     n_res, tag, pos_data, pos_sum, pos_flags, lat);
            check({tag, "_data"}, 64'(pos_data), 64'(e.data));
            check({tag, "_sum"}, 64'(pos_sum), 64'(e.sum));
            check({tag, "_flags"}, 64'(pos_flags), 64'(e.flags));
            if (exp_lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            if (max_lat >= 0) check({tag, "_latency_max"}, 64'(lat <= max_lat), 64'd1);
        end
    endtask

    task automatic run(input string tag, input int l, input int r, input int kind,
                       input int exp_lat, input int max_lat, input int ovr_n);
        push_expected(l, r, kind);
        drive_pulse(l, r, kind);
        await_result(tag, exp_lat, max_lat, ovr_n);
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        check("rst_pos_data", 64'(pos_data), 64'd0);
        check("rst_pos_sum", 64'(pos_sum), 64'd0);
        check("rst_flags", 64'(pos_flags), 64'd0);
        check("rst_valid", 64'(pos_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun_cnt), 64'd0);
        rst = 1'b1;
        cyc();

        // Basic centroid: window 10..12, symmetric about 11
        clear_model();
        model_mem[10] = 100; model_mem[11] = 200; model_mem[12] = 100;
        send_frame(-1, 0, 0);
        run("basic", 10, 12, 0, 3 + QW + 4, -1, 0);

        // Fractional result with a clamped negative sample
        clear_model();
        model_mem[20] = 300; model_mem[21] = 100; model_mem[22] = -50;
        send_frame(-1, 0, 0);
        run("frac", 20, 22, 0, 3 + QW + 4, -1, 0);

        // No cluster, and both pulses together (no_cluster wins)
        send_frame(-1, 0, 0);
        run("nocl", 20, 22, 1, -1, 3, 0);
        send_frame(-1, 0, 0);
        run("both", 20, 22, 2, -1, 3, 0);

        // Cluster arrives mid-frame; processing waits for the last channel
        clear_model();
        model_mem[0] = 5;
        push_expected(0, 0, 0);
        send_frame(100, 0, 0);
        await_result("early", 1 + QW + 3, -1, 0);

        // Error windows: reversed, right beyond NCH, zero data
        send_frame(-1, 0, 0);
        run("reversed", 40, 30, 0, -1, 3, 0);
        send_frame(-1, 0, 0);
        run("beyond", 5, 400, 0, -1, 3, 0);
        send_frame(-1, 0, 0);
        run("zerosum", 50, 52, 0, -1, -1, 0);

        // Overrun: samples while busy are counted and dropped
        clear_model();
        model_mem[200] = 7; model_mem[203] = 21; model_mem[319] = -9;
        send_frame(-1, 0, 0);
        run("overrun", 198, 319, 0, 122 + QW + 4, -1, 7);
        check("overrun_cnt", 64'(overrun_cnt), 64'd7);

        // Reset during DIVIDE abandons the frame
        clear_model();
        model_mem[30] = 50; model_mem[31] = 50;
        send_frame(-1, 0, 0);
        drive_pulse(30, 31, 0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            clear_pulse();
        end
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_data", 64'(pos_data), 64'd0);
        check("mid_rst_sum", 64'(pos_sum), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_overrun", 64'(overrun_cnt), 64'd0);
        cyc();
        cyc();
        rst = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                cyc();
                if (pos_valid) seen++;
            end
            check("no_valid_after_rst", 64'(seen), 64'd0);
        end

        // Next frame after reset is processed normally
        send_frame(-1, 0, 0);
        run("post_rst", 30, 31, 0, 2 + QW + 4, -1, 0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/beam_centroid.md
Name: beam_centroid

Overview:
- Sits directly downstream of the background-subtraction / cluster-locate / calibration top.
- Consumes the per-channel calibrated stream (`data_caled_address`, `data_caled`) and the per-frame cluster result (`sig_ch_left`, `sig_ch_right`, `has_cluster`, `no_cluster`).
- Buffers one frame of calibrated channels, then sums the channels inside the located cluster window.
- Computes the beam centroid in fixed point with a sequential divider and emits one result per frame.

Parameters:
- NCH, 320: channels per frame; valid addresses are 0..NCH-1.
- DATA_W, 32: width of calibrated sample, signed two's complement.
- FRAC_BITS, 8: fractional bits of the centroid output.
- QW, 17: quotient width; must satisfy 2^QW > (NCH-1)·2^FRAC_BITS.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `data_caled_valid`  in  1  calibrated-sample strobe.
- `data_caled_address`  in  9  channel index of the sample.
- `data_caled`  in  DATA_W  calibrated sample.
- `sig_ch_left`  in  9  first channel of the cluster.
- `sig_ch_right`  in  9  last channel of the cluster.
- `has_cluster`  in  1  one-cycle pulse: cluster found this frame.
- `no_cluster`  in  1  one-cycle pulse: no cluster this frame.
- `pos_data`  out  QW  centroid, unsigned, FRAC_BITS fractional bits (Q9.8).
- `pos_sum`  out  41  sum of clamped samples in the window.
- `pos_flags`  out  2  bit0 = no cluster; bit1 = error (bad window or zero sum).
- `pos_valid`  out  1  one-cycle result strobe.
- `busy`  out  1  high from frame complete until `pos_valid`.
- `overrun_cnt`  out  16  count of samples dropped while busy; saturates at 0xFFFF.

Behaviour:

Reset
- `rst` low, asynchronous: all outputs and state registers go to 0; state = COLLECT; cluster-latch flags cleared.
- Buffer RAM contents are not reset.
- Reset asserted mid-ACCUM or mid-DIVIDE abandons the frame; no `pos_valid` is issued for it.

Buffer
- Inferred NCH x DATA_W single-port RAM with 1-cycle read latency.
- In COLLECT, each `data_caled_valid` writes `data_caled` at `data_caled_address`.
- Addresses ≥ NCH are ignored.

Cluster latch
- `has_cluster` or `no_cluster` pulse in any state except ACCUM/DIVIDE/DONE: latch left, right and the kind of pulse; set `cl_seen`.
- If both pulses are high in the same cycle, `no_cluster` wins.
- A second pulse before processing starts overwrites the latched values.

State machine
- COLLECT: a write to address NCH-1 sets `frame_done`. When `frame_done` and `cl_seen` are both set (in either order, including the same cycle), go to CHECK and raise `busy`.
- CHECK (1 cycle):
  - latched `no_cluster` → DONE with flags = 01, `pos_data` = 0, `pos_sum` = 0.
  - left > right, or right ≥ NCH → DONE with flags = 10, `pos_data` = 0, `pos_sum` = 0.
  - otherwise → ACCUM.
- ACCUM:
  - Issue read addresses left..right, one per cycle; N = right − left + 1.
  - Each returned sample s is clamped to 0 if negative.
  - `sum` += s (41 bits). `wsum` += ch·s (50 bits), where ch is the channel index of that sample.
  - Lasts N+1 cycles, including the read-latency drain, then → DIVIDE.
- DIVIDE:
  - Restoring division of (`wsum` << FRAC_BITS) by `sum`, one quotient bit per cycle, QW cycles.
  - If `sum` == 0, skip the division: flags = 10, `pos_data` = 0, `pos_sum` = 0.
  - Then → DONE.
- DONE (1 cycle):
  - Register `pos_data`, `pos_sum`, `pos_flags`; pulse `pos_valid`.
  - Clear `busy`, `frame_done`, `cl_seen`; → COLLECT.

Timing and boundaries
- Latency: `pos_valid` is high exactly N+1+QW+1 cycles after the first ACCUM cycle (N+19 with default parameters). From CHECK it is 1 cycle on the no_cluster and error paths.
- `data_caled_valid` while `busy`: sample dropped, `overrun_cnt` += 1, saturating.
- Outputs hold their values between `pos_valid` pulses.
- Fractional bits are truncated, not rounded.

Test Plan:
- Basic centroid: full frame with ch10 = 100, ch11 = 200, ch12 = 100, all others 0; `has_cluster` with left = 10, right = 12 → `pos_valid` after 3+19 = 22 cycles from ACCUM entry, `pos_data` = 2816 (11.0), `pos_sum` = 400, flags = 00.
- Fractional and clamp: ch20 = 300, ch21 = 100, ch22 = −50; window 20..22 → `pos_sum` = 400, `pos_data` = floor(8100·256/400) = 5184 (20.25), flags = 00.
- No cluster: full frame, then `no_cluster` pulse → `pos_valid` 2 cycles later with flags = 01, `pos_data` = 0, `pos_sum` = 0.
- Cluster before frame end: `has_cluster` (left = 0, right = 0) arrives mid-frame with ch0 = 5 → processing starts only after the address-319 write; `pos_data` = 0, `pos_sum` = 5.
- Errors: window 40..30 → flags = 10; window 50..52 with all-zero data → flags = 10, `pos_sum` = 0.
- Overrun and reset: send 7 samples while `busy` → `overrun_cnt` = 7 and the result is unaffected. Assert `rst` low during DIVIDE → outputs 0 immediately, no `pos_valid`, next full frame processed normally.
